// File: rtl/rsa_pkg.sv
// rsa_pkg: shared widths, packer FSM encoding and constants
// for the RSA plaintext packer and key sizer.
package rsa_pkg;

  localparam int KEY_W = 32;
  localparam int CNT_W = 5;

  localparam logic [7:0] NUL = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    SIZING,
    WAIT,
    SHIFT,
    EMIT,
    FLUSH,
    DONE
  } pk_state_t;

endpackage

// File: rtl/key_sizer.sv
// key_sizer: measures the bit length of a key, one bit per clock,
// pulsing o_done when the shifted copy reaches zero.
module key_sizer #(
  parameter int KEY_W = rsa_pkg::KEY_W,
  parameter int CNT_W = rsa_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_n_key,
  output logic [CNT_W:0]   o_n_len,
  output logic             o_done
);

  localparam logic [CNT_W:0] LEN_ONE = 1;

  logic [KEY_W-1:0] r_buf;
  logic [CNT_W:0]   r_len;
  logic             r_active;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf    <= '0;
      r_len    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_buf    <= i_n_key;
      r_len    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_buf != '0) begin
        r_buf <= r_buf >> 1;
        r_len <= r_len + LEN_ONE;
      end else begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_n_len = r_len;
  assign o_done  = r_active && (r_buf == '0);

endmodule

// File: rtl/plain_packer.sv
// plain_packer: packs received bytes LSB-first into (n_len-1)-bit words.
// Optional PLAIN_PACKER_OVERRUN_EN keeps the held byte and flags overrun.
module plain_packer #(
  parameter int KEY_W = rsa_pkg::KEY_W,
  parameter int CNT_W = rsa_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] n_key,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  input  logic             fme_ready,
  output logic             word_valid,
  output logic [KEY_W-1:0] word_out,
  output logic             last_word_tick,
  output logic             busy,
  output logic             key_err,
  output logic             done_tick
`ifdef PLAIN_PACKER_OVERRUN_EN
  ,
  output logic             overrun
`endif
);

  import rsa_pkg::*;

  localparam logic [CNT_W:0]   LEN_MIN = 3;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  pk_state_t r_state;
  pk_state_t w_next;

  logic [CNT_W:0]   w_n_len;
  logic             w_size_done;
  logic             w_key_bad;
  logic             w_start;
  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] r_pc;
  logic [CNT_W-1:0] w_pc_nxt;
  logic [3:0]       r_bit;
  logic [7:0]       r_byte;
  logic [7:0]       r_hold;
  logic             r_hold_full;
  logic             r_last;
  logic [KEY_W-1:0] r_pack;
  logic             w_word_full;
  logic             w_byte_end;
  logic             w_nul;
  logic             w_fire;
  logic             w_cap;

  assign w_start     = start && (r_state == IDLE);
  assign w_key_bad   = w_n_len < LEN_MIN;
  assign w_pc_nxt    = r_pc + CNT_ONE;
  assign w_word_full = w_pc_nxt == r_k;
  assign w_byte_end  = r_bit == 4'd7;
  assign w_nul       = r_byte == NUL;
  assign w_fire      = (r_state == EMIT) && fme_ready && !rst;
  assign w_cap       = rx_done_tick &&
                       ((r_state == SHIFT) || (r_state == EMIT) ||
                        ((r_state == WAIT) && r_hold_full));

  key_sizer #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_sizer (
    .clk    (clk),
    .rst    (rst),
    .i_start(w_start),
    .i_n_key(n_key),
    .o_n_len(w_n_len),
    .o_done (w_size_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = SIZING;
      SIZING: if (w_size_done) w_next = w_key_bad ? IDLE : WAIT;
      WAIT:   if (r_hold_full || rx_done_tick) w_next = SHIFT;
      SHIFT: begin
        if (w_word_full)     w_next = EMIT;
        else if (w_byte_end) w_next = w_nul ? FLUSH : WAIT;
      end
      EMIT: begin
        if (fme_ready) begin
          if (r_last)      w_next = DONE;
          else if (!r_bit[3]) w_next = SHIFT;
          else             w_next = WAIT;
        end
      end
      FLUSH:   w_next = (r_pc != '0) ? EMIT : DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

`ifdef PLAIN_PACKER_OVERRUN_EN
  logic r_overrun;
  assign overrun = r_overrun;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_pc        <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_last      <= 1'b0;
      r_pack      <= '0;
`ifdef PLAIN_PACKER_OVERRUN_EN
      r_overrun   <= 1'b0;
`endif
    end else begin
      case (r_state)
        SIZING: begin
          if (w_size_done && !w_key_bad) begin
            r_k         <= w_n_len[CNT_W-1:0] - CNT_ONE;
            r_pc        <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_last      <= 1'b0;
            r_pack      <= '0;
          end
        end
        WAIT: begin
          if (r_hold_full) begin
            r_byte      <= r_hold;
            r_bit       <= '0;
            r_hold_full <= 1'b0;
          end else if (rx_done_tick) begin
            r_byte <= rx_data;
            r_bit  <= '0;
          end
        end
        SHIFT: begin
          r_pack[r_pc] <= r_byte[r_bit[2:0]];
          r_pc         <= w_pc_nxt;
          r_bit        <= r_bit + 4'd1;
          // NUL finishing exactly on a word boundary makes that word last
          if (w_word_full) r_last <= w_byte_end && w_nul;
        end
        EMIT: begin
          if (fme_ready) begin
            r_pack <= '0;
            r_pc   <= '0;
          end
        end
        FLUSH:   if (r_pc != '0) r_last <= 1'b1;
        DONE:    r_last <= 1'b0;
        default: ;
      endcase
`ifdef PLAIN_PACKER_OVERRUN_EN
      if (w_cap) begin
        if (r_hold_full && (r_state != WAIT)) begin
          r_overrun <= 1'b1;
        end else begin
          r_hold      <= rx_data;
          r_hold_full <= 1'b1;
        end
      end
      if (w_start) r_overrun <= 1'b0;
`else
      if (w_cap) begin
        r_hold      <= rx_data;
        r_hold_full <= 1'b1;
      end
`endif
    end
  end

  always_comb begin
    busy           = r_state != IDLE;
    word_valid     = w_fire;
    last_word_tick = w_fire && r_last;
    key_err        = (r_state == SIZING) && w_size_done && w_key_bad && !rst;
    done_tick      = (r_state == DONE) && !rst;
  end

  assign word_out = r_pack;

endmodule

// File: tb/tb_plain_packer.sv
// tb_plain_packer: directed and randomized messages checked against a
// bit-stream reference model; define PLAIN_PACKER_OVERRUN_EN for overrun.
module tb_plain_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n_key = '0;
  logic        rx_done_tick = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        fme_ready = 1'b1;
  logic        word_valid;
  logic [31:0] word_out;
  logic        last_word_tick;
  logic        busy;
  logic        key_err;
  logic        done_tick;
`ifdef PLAIN_PACKER_OVERRUN_EN
  logic        overrun;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  plain_packer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .n_key         (n_key),
    .rx_done_tick  (rx_done_tick),
    .rx_data       (rx_data),
    .fme_ready     (fme_ready),
    .word_valid    (word_valid),
    .word_out      (word_out),
    .last_word_tick(last_word_tick),
    .busy          (busy),
    .key_err       (key_err),
    .done_tick     (done_tick)
`ifdef PLAIN_PACKER_OVERRUN_EN
    ,
    .overrun       (overrun)
`endif
  );

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  logic [7:0]  msg_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          cur_k = 7;

  function automatic int bitlen(input logic [31:0] v);
    int n;
    n = 0;
    while (v != 0) begin
      v = v >> 1;
      n++;
    end
    return n;
  endfunction

  // message bits laid end to end LSB-first, cut into k-bit words
  function automatic void build_model(input int k);
    int nbits;
    int nw;
    nbits = 8 * msg_q.size();
    nw = (nbits + k - 1) / k;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      logic [31:0] word;
      word = '0;
      for (int b = 0; b < k; b++) begin
        int idx;
        idx = w * k + b;
        if (idx < nbits) word[b] = msg_q[idx / 8][idx % 8];
      end
      exp_q.push_back(word);
    end
  endfunction

  function automatic void roundtrip(input int k);
    for (int i = 0; i < msg_q.size(); i++) begin
      logic [7:0] by;
      by = '0;
      for (int j = 0; j < 8; j++) begin
        int idx;
        idx = i * 8 + j;
        if (idx / k < got_q.size()) by[j] = got_q[idx / k][idx % k];
      end
      chk("roundtrip_byte", 32'(by), 32'(msg_q[i]));
    end
  endfunction

  int cyc = 0;
  int last_cyc = -10;
  int wv_count = 0;
  bit expect_keyerr = 1'b0;
  bit got_keyerr = 1'b0;
  bit got_done = 1'b0;

  always @(negedge clk) begin
    logic [31:0] e;
    cyc++;
    chk("tick_without_word", 32'(last_word_tick & ~word_valid), 32'd0);
    if (word_valid) begin
      wv_count++;
      got_q.push_back(word_out);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", word_out);
      end else begin
        e = exp_q.pop_front();
        chk("word", word_out, e);
        chk("last_flag", 32'(last_word_tick), 32'(exp_q.size() == 0));
        if (last_word_tick) last_cyc = cyc;
      end
    end
    if (done_tick) begin
      got_done = 1'b1;
      chk("done_latency", 32'(cyc - last_cyc), 32'd1);
    end
    if (key_err) begin
      got_keyerr = 1'b1;
      chk("key_err_allowed", 32'(expect_keyerr), 32'd1);
    end
  end

  int fmode = 0;
  initial begin
    int lows;
    lows = 0;
    forever begin
      @(posedge clk);
      #1;
      if (fmode == 1) fme_ready = 1'b0;
      else if (fmode == 2) fme_ready = 1'b1;
      else if (lows < 3 && $urandom_range(0, 3) == 0) begin
        fme_ready = 1'b0;
        lows++;
      end else begin
        fme_ready = 1'b1;
        lows = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done_tick = 1'b1;
    tick(1);
    rx_done_tick = 1'b0;
  endtask

  task automatic setup(input logic [31:0] key);
    cur_k = bitlen(key) - 1;
    build_model(cur_k);
    got_q.delete();
    got_done = 1'b0;
  endtask

  task automatic begin_msg(input logic [31:0] key);
    n_key = key;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_key = $urandom;
`ifdef PLAIN_PACKER_OVERRUN_EN
    chk("overrun_cleared_by_start", 32'(overrun), 32'd0);
`endif
    tick(40);
  endtask

  task automatic wait_done();
    int nw;
    nw = (8 * msg_q.size() + cur_k - 1) / cur_k;
    for (int c = 0; c < 3000 && !got_done; c++) tick(1);
    chk("done_seen", 32'(got_done), 32'd1);
    chk("words_left", 32'(exp_q.size()), 32'd0);
    chk("word_count", 32'(got_q.size()), 32'(nw));
    roundtrip(cur_k);
    tick(2);
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic keyerr_case(input logic [31:0] key);
    int wv0;
    wv0 = wv_count;
    expect_keyerr = 1'b1;
    got_keyerr = 1'b0;
    n_key = key;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int c = 0; c < 10 && !got_keyerr; c++) tick(1);
    chk("key_err_seen", 32'(got_keyerr), 32'd1);
    tick(2);
    chk("key_err_idle", 32'(busy), 32'd0);
    chk("key_err_no_word", 32'(wv_count), 32'(wv0));
    expect_keyerr = 1'b0;
  endtask

  initial begin
    logic [7:0] b1, b2, b3;
    int wv0;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_word_valid", 32'(word_valid), 32'd0);
    chk("rst_word_out", word_out, 32'd0);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_key_err", 32'(key_err), 32'd0);
    tick(1);

    chk("pin_nlen_fb", 32'(bitlen(32'hFB)), 32'd8);
    msg_q = '{8'h00};
    setup(32'hFB);
    chk("pin_nul_only_words", 32'(exp_q.size()), 32'd2);

    // 'A', NUL with k = 7
    msg_q = '{8'h41, 8'h00};
    setup(32'hFB);
    chk("pin_t1_count", 32'(exp_q.size()), 32'd3);
    chk("pin_t1_w0", exp_q[0], 32'h41);
    chk("pin_t1_w1", exp_q[1], 32'h00);
    chk("pin_t1_w2", exp_q[2], 32'h00);
    exp_q = '{32'h41, 32'h00, 32'h00};
    begin_msg(32'hFB);
    send_byte(8'h41);
    tick(45);
    send_byte(8'h00);
    wait_done();

    // "Hi", NUL with k = 15
    msg_q = '{8'h48, 8'h69, 8'h00};
    setup(32'hFFFF);
    chk("pin_t2_count", 32'(exp_q.size()), 32'd2);
    chk("pin_t2_w0", exp_q[0], 32'h6948);
    chk("pin_t2_w1", exp_q[1], 32'h0000);
    exp_q = '{32'h6948, 32'h0000};
    begin_msg(32'hFFFF);
    foreach (msg_q[i]) begin
      send_byte(msg_q[i]);
      tick(45);
    end
    wait_done();

    keyerr_case(32'h3);
    keyerr_case(32'h0);

    // consumer stall with a byte parked in the hold buffer
    b1 = 8'($urandom_range(1, 255));
    b2 = 8'($urandom_range(1, 255));
    msg_q = '{b1, b2, 8'h00};
    setup(32'hFB);
    fmode = 1;
    begin_msg(32'hFB);
    send_byte(b1);
    tick(10);
    wv0 = wv_count;
    send_byte(b2);
    tick(50);
    chk("stall_no_word", 32'(wv_count), 32'(wv0));
    chk("stall_busy", 32'(busy), 32'd1);
    fmode = 0;
    tick(50);
    send_byte(8'h00);
    wait_done();

    // three back-to-back bytes: second and third contend for the hold
    b1 = 8'($urandom_range(1, 255));
    b2 = 8'($urandom_range(1, 127));
    b3 = 8'($urandom_range(128, 255));
`ifdef PLAIN_PACKER_OVERRUN_EN
    msg_q = '{b1, b2, 8'h00};
`else
    msg_q = '{b1, b3, 8'h00};
`endif
    setup(32'hFB);
    fmode = 1;
    begin_msg(32'hFB);
    rx_done_tick = 1'b1;
    rx_data = b1;
    tick(1);
    rx_data = b2;
    tick(1);
    rx_data = b3;
    tick(1);
    rx_done_tick = 1'b0;
    tick(20);
`ifdef PLAIN_PACKER_OVERRUN_EN
    chk("overrun_set", 32'(overrun), 32'd1);
`endif
    fmode = 0;
    tick(60);
    send_byte(8'h00);
    wait_done();
`ifdef PLAIN_PACKER_OVERRUN_EN
    chk("overrun_sticky", 32'(overrun), 32'd1);
`endif

    // reset in the middle of shifting a byte
    msg_q = '{8'h55};
    setup(32'hFFFF);
    begin_msg(32'hFFFF);
    send_byte(8'h55);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_word_valid", 32'(word_valid), 32'd0);
    chk("midrst_word_out", word_out, 32'd0);
    chk("midrst_last", 32'(last_word_tick), 32'd0);
    chk("midrst_done", 32'(done_tick), 32'd0);
    chk("midrst_key_err", 32'(key_err), 32'd0);
`ifdef PLAIN_PACKER_OVERRUN_EN
    chk("midrst_overrun", 32'(overrun), 32'd0);
`endif
    exp_q.delete();
    tick(1);

    for (int m = 0; m < 15; m++) begin
      int L;
      int nb;
      logic [31:0] key;
      logic [31:0] mask;
      L = $urandom_range(3, 32);
      mask = (L == 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
      key = ($urandom | (32'd1 << (L - 1))) & mask;
      nb = $urandom_range(0, 5);
      msg_q.delete();
      for (int i = 0; i < nb; i++) msg_q.push_back(8'($urandom_range(1, 255)));
      msg_q.push_back(8'h00);
      setup(key);
      begin_msg(key);
      foreach (msg_q[i]) begin
        send_byte(msg_q[i]);
        tick($urandom_range(40, 70));
      end
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
